// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter for up to four masters sharing one AHB-Lite
// slave fabric. It drives a one-hot HGRANTx, HMASTER (address-phase owner),
// the data-phase owner index and HMASTLOCK. The grant is held across
// fixed-length bursts and locked sequences. Master 0 is the default master.
//
// Build option: define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest
// requesting index wins, no round-robin pointer). Left undefined, the
// arbiter is round-robin.
//
// Handshake: bus_ready_in is HREADY. Every register, including the FSM,
// burst counter, pointer and output pipeline, advances only on a
// bus_clk_in rising edge where bus_ready_in=1. With bus_ready_in=0 all
// state and outputs hold. There is no other flow control.
//
// arb_state_out exposes the FSM state for observation:
// 0 = ARB, 1 = BURST, 2 = LOCKED.

module ahb_arbiter #(
    parameter  int MASTERS = 4,
    localparam int MW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               bus_clk_in,
    input  logic               bus_rstn_in,
    input  logic [MASTERS-1:0] master_busreq_in,
    input  logic [MASTERS-1:0] master_lock_in,
    input  logic [1:0]         bus_trans_in,
    input  logic [2:0]         bus_burst_in,
    input  logic               bus_ready_in,
    output logic [MASTERS-1:0] master_grant_out,
    output logic [MW-1:0]      master_sel_out,
    output logic [MW-1:0]      master_data_sel_out,
    output logic               master_lock_out,
    output logic [1:0]         arb_state_out
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    state_t             r_state;
    logic [MASTERS-1:0] r_grant;
    logic [MW-1:0]      r_sel;
    logic [MW-1:0]      r_data_sel;
    logic               r_lock;
    logic [3:0]         r_cnt;
`ifndef AHB_ARB_FIXED_PRIO_EN
    logic [MW-1:0]      r_rr;
    logic [MW-1:0]      w_next_rr;
`endif

    logic [MW-1:0]      w_owner;
    logic               w_owner_lock;
    logic               w_req_valid;
    logic [MW-1:0]      w_req_idx;
    logic               w_win_valid;
    logic [MW-1:0]      w_win_idx;
    logic [MASTERS-1:0] w_win_grant;
    logic               w_burst_start;
    logic [3:0]         w_beats_m1;
    logic               w_do_arb;

    // Encode the one-hot grant into the current address owner index.
    always_comb begin
        w_owner = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (r_grant[i]) begin
                w_owner = MW'(i);
            end
        end
    end

    assign w_owner_lock = master_lock_in[w_owner];

    // Pick the requesting master that would win a fresh arbitration.
`ifdef AHB_ARB_FIXED_PRIO_EN
    always_comb begin
        w_req_valid = 1'b0;
        w_req_idx   = '0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            if (master_busreq_in[i]) begin
                w_req_valid = 1'b1;
                w_req_idx   = MW'(i);
            end
        end
    end
`else
    always_comb begin
        int j;
        w_req_valid = 1'b0;
        w_req_idx   = '0;
        j           = 0;
        for (int k = 0; k < MASTERS; k++) begin
            j = int'(r_rr) + k;
            if (j >= MASTERS) begin
                j = j - MASTERS;
            end
            if (!w_req_valid && master_busreq_in[MW'(j)]) begin
                w_req_valid = 1'b1;
                w_req_idx   = MW'(j);
            end
        end
    end
`endif

    // A locked owner keeps the bus unconditionally; otherwise the requester
    // search decides, and with nobody requesting the default master 0 wins.
    always_comb begin
        logic [MW-1:0] idx_eff;
        w_win_valid = w_owner_lock | w_req_valid;
        w_win_idx   = w_owner_lock ? w_owner : w_req_idx;
        idx_eff     = w_win_valid ? w_win_idx : '0;
        w_win_grant = '0;
        for (int i = 0; i < MASTERS; i++) begin
            w_win_grant[i] = (idx_eff == MW'(i));
        end
    end

`ifndef AHB_ARB_FIXED_PRIO_EN
    assign w_next_rr = (w_win_idx == MW'(MASTERS - 1)) ? '0 : (w_win_idx + MW'(1));
`endif

    // Decode the remaining beat count for a fixed-length burst start.
    always_comb begin
        case (bus_burst_in)
            3'd2, 3'd3: w_beats_m1 = 4'd3;
            3'd4, 3'd5: w_beats_m1 = 4'd7;
            3'd6, 3'd7: w_beats_m1 = 4'd15;
            default:    w_beats_m1 = 4'd0;
        endcase
    end

    assign w_burst_start = (bus_trans_in == TR_NONSEQ) && (bus_burst_in >= 3'd2);

    // Decide whether this ready edge re-arbitrates or holds the grant.
    always_comb begin
        w_do_arb = 1'b0;
        case (r_state)
            ST_ARB:    w_do_arb = w_owner_lock || !w_burst_start;
            ST_BURST:  w_do_arb = ((bus_trans_in == TR_SEQ) && (r_cnt == 4'd1))
                                  || (bus_trans_in == TR_IDLE)
                                  || (bus_trans_in == TR_NONSEQ);
            ST_LOCKED: w_do_arb = !w_owner_lock;
            default:   w_do_arb = 1'b1;
        endcase
    end

    // Arbiter FSM with registered grant, owner pipeline and lock output.
    always_ff @(posedge bus_clk_in or negedge bus_rstn_in) begin
        if (!bus_rstn_in) begin
            r_state    <= ST_ARB;
            r_grant    <= MASTERS'(1);
            r_sel      <= '0;
            r_data_sel <= '0;
            r_lock     <= 1'b0;
            r_cnt      <= 4'd0;
`ifndef AHB_ARB_FIXED_PRIO_EN
            r_rr       <= '0;
`endif
        end else if (bus_ready_in) begin
            r_sel      <= w_owner;
            r_data_sel <= r_sel;
            r_lock     <= w_owner_lock;

            if (w_do_arb) begin
                r_grant <= w_win_grant;
`ifndef AHB_ARB_FIXED_PRIO_EN
                if (w_win_valid) begin
                    r_rr <= w_next_rr;
                end
`endif
            end

            case (r_state)
                ST_ARB: begin
                    if (w_owner_lock) begin
                        r_state <= ST_LOCKED;
                    end else if (w_burst_start) begin
                        r_cnt   <= w_beats_m1;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (bus_trans_in == TR_SEQ) begin
                        if (r_cnt == 4'd1) begin
                            r_cnt   <= 4'd0;
                            r_state <= ST_ARB;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end else if (bus_trans_in != TR_BUSY) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_ARB;
                    end
                end
                ST_LOCKED: begin
                    if (!w_owner_lock) begin
                        r_state <= ST_ARB;
                    end
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign master_grant_out    = r_grant;
    assign master_sel_out      = r_sel;
    assign master_data_sel_out = r_data_sel;
    assign master_lock_out     = r_lock;
    assign arb_state_out       = r_state;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed vector table, hand sequences for bursts, wait
// states, locking and mid-burst reset, then random traffic compared against
// a behavioural model of the arbitration rules.

module tb_ahb_arbiter;

    localparam int N = 4;

    localparam int M_ARB    = 0;
    localparam int M_BURST  = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [1:0] dsel;
    logic       lock_o;
    logic [1:0] st;

    int n_checks = 0;
    int n_err    = 0;

    // behavioural model state
    int m_owner;
    int m_sel;
    int m_dsel;
    int m_rr;
    int m_mode;
    int m_left;
    bit m_lock;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [3:0] g;
        logic [1:0] s;
        logic [1:0] d;
        logic       l;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ahb_arbiter #(.MASTERS(N)) dut (
        .bus_clk_in          (clk),
        .bus_rstn_in         (rstn),
        .master_busreq_in    (req),
        .master_lock_in      (lock),
        .bus_trans_in        (trans),
        .bus_burst_in        (burst),
        .bus_ready_in        (rdy),
        .master_grant_out    (grant),
        .master_sel_out      (sel),
        .master_data_sel_out (dsel),
        .master_lock_out     (lock_o),
        .arb_state_out       (st)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int beats(input int b);
        return 4 << (b / 2 - 1);
    endfunction

    // Winner of an arbitration under the current inputs, -1 if nobody asks.
    function automatic int pick();
        if (lock[m_owner]) return m_owner;
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (req[k]) return k;
`else
        for (int k = 0; k < N; k++) if (req[(m_rr + k) % N]) return (m_rr + k) % N;
`endif
        return -1;
    endfunction

    task automatic rearb();
        int w;
        w = pick();
        if (w >= 0) begin
            m_owner = w;
            m_rr    = (w + 1) % N;
        end else begin
            m_owner = 0;
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_sel   = 0;
        m_dsel  = 0;
        m_rr    = 0;
        m_mode  = M_ARB;
        m_left  = 0;
        m_lock  = 0;
    endtask

    task automatic model_edge();
        int o;
        bit lk;
        if (!rdy) return;
        o      = m_owner;
        lk     = lock[o];
        m_dsel = m_sel;
        m_sel  = o;
        m_lock = lk;
        case (m_mode)
            M_ARB: begin
                if (lk) begin
                    rearb();
                    m_mode = M_LOCKED;
                end else if (trans == 2 && burst >= 2) begin
                    m_left = beats(int'(burst)) - 1;
                    m_mode = M_BURST;
                end else begin
                    rearb();
                end
            end
            M_BURST: begin
                if (trans == 3) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_ARB;
                        rearb();
                    end
                end else if (trans != 1) begin
                    m_mode = M_ARB;
                    rearb();
                end
            end
            default: begin
                if (!lk) begin
                    m_mode = M_ARB;
                    rearb();
                end
            end
        endcase
    endtask

    task automatic check_model();
        check("model_grant", 32'(grant), 32'(1) << m_owner);
        check("model_sel", 32'(sel), 32'(m_sel));
        check("model_dsel", 32'(dsel), 32'(m_dsel));
        check("model_lock", 32'(lock_o), 32'(m_lock));
        check("model_state", 32'(st), 32'(m_mode));
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                        input logic [2:0] b, input logic y);
        req   = r;
        lock  = l;
        trans = t;
        burst = b;
        rdy   = y;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset applied between clock edges; outputs must drop at once.
    task automatic do_reset();
        rstn = 1'b0;
        #2;
        model_reset();
        check("rst_grant", 32'(grant), 32'h1);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_dsel", 32'(dsel), 32'h0);
        check("rst_lock", 32'(lock_o), 32'h0);
        check("rst_state", 32'(st), 32'h0);
        rstn = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s_exp);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_state"}, 32'(st), 32'(s_exp));
    endtask

    initial begin
        rstn  = 1'b0;
        req   = '0;
        lock  = '0;
        trans = '0;
        burst = '0;
        rdy   = 1'b1;
        model_reset();
        #6;
        do_reset();

        // directed vector table, applied from reset
`ifdef AHB_ARB_FIXED_PRIO_EN
        tbl.push_back('{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b1100, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b1100, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b1100, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 2'd0});
        tbl.push_back('{4'b1100, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 2'd0});
        tbl.push_back('{4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0, 2'd0});
        tbl.push_back('{4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b1000, 2'd1, 2'd2, 1'b0, 2'd0});
`else
        tbl.push_back('{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b1000, 2'd1, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd3, 2'd1, 1'b0, 2'd0});
        tbl.push_back('{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd1, 2'd3, 1'b0, 2'd0});
        tbl.push_back('{4'b0001, 4'b0000, 2'd0, 3'd0, 1'b0, 4'b0001, 2'd1, 2'd3, 1'b0, 2'd0});
        tbl.push_back('{4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd1, 1'b0, 2'd0});
        tbl.push_back('{4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0, 2'd0});
        tbl.push_back('{4'b0011, 4'b0010, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b1, 2'd2});
        tbl.push_back('{4'b0001, 4'b0010, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b1, 2'd2});
        tbl.push_back('{4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd1, 2'd1, 1'b0, 2'd0});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].rdy);
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].s));
            check($sformatf("tbl%0d_dsel", i), 32'(dsel), 32'(tbl[i].d));
            check($sformatf("tbl%0d_lock", i), 32'(lock_o), 32'(tbl[i].l));
            check($sformatf("tbl%0d_state", i), 32'(st), 32'(tbl[i].st));
        end

        // INCR4 by m1 with m2 waiting; m1 drops its request mid-burst
        do_reset();
        step(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1);
        expect_out("a_arb", 4'b0010, 2'd0);
        step(4'b0100, 4'b0000, 2'd2, 3'd3, 1'b1);
        expect_out("a_nonseq", 4'b0010, 2'd1);
        step(4'b0100, 4'b0000, 2'd3, 3'd3, 1'b1);
        expect_out("a_seq1", 4'b0010, 2'd1);
        step(4'b0100, 4'b0000, 2'd3, 3'd3, 1'b1);
        expect_out("a_seq2", 4'b0010, 2'd1);
        for (int w = 0; w < 2; w++) begin
            step(4'b0100, 4'b0000, 2'd3, 3'd3, 1'b0);
            expect_out("a_wait", 4'b0010, 2'd1);
            check("a_wait_sel", 32'(sel), 32'h1);
            check("a_wait_dsel", 32'(dsel), 32'h1);
            check("a_wait_lock", 32'(lock_o), 32'h0);
        end
        step(4'b0100, 4'b0000, 2'd3, 3'd3, 1'b1);
        expect_out("a_last", 4'b0100, 2'd0);

        // WRAP8 by m2 cut short by IDLE after three beats, m3 waiting
        step(4'b1000, 4'b0000, 2'd2, 3'd4, 1'b1);
        expect_out("b_nonseq", 4'b0100, 2'd1);
        step(4'b1000, 4'b0000, 2'd3, 3'd4, 1'b1);
        step(4'b1000, 4'b0000, 2'd3, 3'd4, 1'b1);
        expect_out("b_seq", 4'b0100, 2'd1);
        step(4'b1000, 4'b0000, 2'd0, 3'd4, 1'b1);
        expect_out("b_idle", 4'b1000, 2'd0);

        // locked sequence by m0 with everyone requesting
        do_reset();
        for (int e = 0; e < 5; e++) begin
            step(4'b1111, 4'b0001, 2'd0, 3'd0, 1'b1);
            expect_out("c_locked", 4'b0001, 2'd2);
            check("c_lock_out", 32'(lock_o), 32'h1);
        end
        step(4'b1111, 4'b0000, 2'd0, 3'd0, 1'b1);
`ifdef AHB_ARB_FIXED_PRIO_EN
        expect_out("c_unlock", 4'b0001, 2'd0);
`else
        expect_out("c_unlock", 4'b0010, 2'd0);
`endif

        // reset in the middle of an INCR16 leaves no residual count
        do_reset();
        step(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
        step(4'b0011, 4'b0000, 2'd2, 3'd6, 1'b1);
        expect_out("d_burst", 4'b0010, 2'd1);
        step(4'b0011, 4'b0000, 2'd3, 3'd6, 1'b1);
        do_reset();
        step(4'b0001, 4'b0000, 2'd3, 3'd6, 1'b1);
        expect_out("d_after", 4'b0001, 2'd0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] rl;
            rl = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rl[b] = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            step(4'($urandom_range(0, 15)), rl, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
